load_store_unit: RTL

Memory-access stage directly downstream of the ALU in the RV32 core. It takes the ALU result as the effective address, plus the store data and `funct3`, and runs a single request/acknowledge transaction on the data-memory bus. It stalls the core until the bus completes, then returns sign- or zero-extended load data to writeback. It also detects misaligned accesses, illegal `funct3` values and bus timeouts.

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store stage and memory.
// Single request/acknowledge transaction per access.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory-access stage: one bus transaction per load/store,
// with alignment/funct3 checking, bus timeout and load extension.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] LoadData,
  output logic        Stall,
  output logic        MisalignedErr,
  output logic        BusErr,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        valid;
  logic        is_st;
  logic        bad_f3;
  logic        misal;
  logic        err;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld;

  assign valid = MemRead | MemWrite;
  assign is_st = MemWrite;

  always_comb begin
    bad_f3 = 1'b1;
    unique case (funct3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = is_st;
      default:                bad_f3 = 1'b1;
    endcase
  end

  assign misal = (funct3[1:0] == 2'b01 && Addr[0])
              || (funct3 == 3'b010 && Addr[1:0] != 2'b00);
  assign err   = bad_f3 | misal;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = WriteData;
    if (is_st) begin
      unique case (funct3[1:0])
        2'b00: begin
          be_n    = 4'b0001 << Addr[1:0];
          wdata_n = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_n    = Addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{WriteData[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign sh     = bus.mem_rdata >> {off_q, 3'b000};
  assign byte_v = sh[7:0];
  assign half_v = off_q[1] ? bus.mem_rdata[31:16]
                           : bus.mem_rdata[15:0];

  always_comb begin
    ld = bus.mem_rdata;
    unique case (f3_q)
      3'b000:  ld = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld = {{16{half_v[15]}}, half_v};
      3'b100:  ld = {24'h0, byte_v};
      3'b101:  ld = {16'h0, half_v};
      default: ld = bus.mem_rdata;
    endcase
  end

  // Gated by rst_n so the core is released as soon as reset asserts
  assign Stall = rst_n
              && (state == BUS
              || (state == IDLE && valid && !err));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      LoadData      <= '0;
      MisalignedErr <= 1'b0;
      BusErr        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      MisalignedErr <= 1'b0;
      BusErr        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid && err) begin
            MisalignedErr <= 1'b1;
          end else if (valid) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_st;
            bus.mem_addr  <= {Addr[31:2], 2'b00};
            bus.mem_be    <= be_n;
            bus.mem_wdata <= wdata_n;
            f3_q          <= funct3;
            off_q         <= Addr[1:0];
            cnt           <= '0;
            state         <= BUS;
          end
        end
        BUS: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) LoadData <= ld;
            state       <= DONE;
          end else if (cnt == LAST) begin
            bus.mem_req <= 1'b0;
            BusErr      <= 1'b1;
            if (!bus.mem_we) LoadData <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
